// File: rtl/cla_serial_adder.sv
// cla_serial_adder: multi-cycle WIDTH-bit adder, one 2-bit CLA slice per clock,
// LSB slice first, for the sum_board result display and LED logic.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         begin an add; only looked at while idle
//   a, b, c_in    operands and carry-in, captured when start is accepted
//   busy          high while slices are being processed
//   done          one-cycle pulse; sum/c_out/overflow are valid
//   sum           registered sum (cleared on accept, held after done)
//   c_out         registered carry-out
//   overflow      registered two's-complement overflow
//   g_all, p_all  word generate/propagate (only when CLA_GP_OUT_EN is defined)
//
// Optional feature macro: CLA_GP_OUT_EN adds the g_all/p_all outputs and their
// accumulators. Without it the block behaves identically minus those ports.

// One 2-bit carry-lookahead slice. c1 is the carry into the upper bit, which
// on the top slice is the carry into the sign bit and feeds the overflow test.
module cla2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       g,
  output logic       p,
  output logic       c1
);
  logic g0, p0, g1, p1;
  assign g0   = a[0] & b[0];
  assign p0   = a[0] ^ b[0];
  assign g1   = a[1] & b[1];
  assign p1   = a[1] ^ b[1];
  assign c1   = g0 | (p0 & ci);
  assign s    = {p1 ^ c1, p0 ^ ci};
  assign g    = g1 | (p1 & g0);
  assign p    = p1 & p0;
endmodule

module cla_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
`ifdef CLA_GP_OUT_EN
  ,
  output logic             g_all,
  output logic             p_all
`endif
);
  localparam int SLICES = WIDTH / 2;
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] a_q, b_q, a_sh, b_sh;
  logic            carry;
  logic [1:0]      s;
  logic            g, p, c1, co, last;

  // Shift the captured operands so the active slice sits at bit 0.
  assign a_sh = a_q >> {idx, 1'b0};
  assign b_sh = b_q >> {idx, 1'b0};
  assign last = (idx == IW'(SLICES - 1));
  assign co   = g | (p & carry);

  cla2_slice u_slice (
    .a  (a_sh[1:0]),
    .b  (b_sh[1:0]),
    .ci (carry),
    .s  (s),
    .g  (g),
    .p  (p),
    .c1 (c1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef CLA_GP_OUT_EN
  logic gacc, pacc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
`ifdef CLA_GP_OUT_EN
      gacc     <= 1'b0;
      pacc     <= 1'b1;
      g_all    <= 1'b0;
      p_all    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          carry <= c_in;
          idx   <= '0;
          sum   <= '0;
`ifdef CLA_GP_OUT_EN
          gacc  <= 1'b0;
          pacc  <= 1'b1;
`endif
        end
        RUN: begin
          carry                  <= co;
          sum[{idx, 1'b0} +: 2]  <= s;
          idx                    <= idx + 1'b1;
`ifdef CLA_GP_OUT_EN
          gacc <= g | (p & gacc);
          pacc <= pacc & p;
`endif
          if (last) begin
            c_out    <= co;
            // Carry out of the sign bit disagreeing with carry into it.
            overflow <= co ^ c1;
`ifdef CLA_GP_OUT_EN
            g_all    <= g | (p & gacc);
            p_all    <= pacc & p;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule
